lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit: the initiator side of the data memory interface. Sits between the MEM pipeline stage and the byte-addressed data memory.
- The data memory reads whole words combinationally and writes whole words only. This block turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned word transactions.
- Loads: the block extracts the addressed byte or halfword and sign- or zero-extends it.
- Sub-word stores: done as read-modify-write (RMW).
- Misaligned accesses are flagged.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; used only by the bounds check.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  core requests an access.
- req_ready_o  out  1  high only in IDLE; a request is accepted when req_valid_i && req_ready_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data (low bits used for SB/SH).
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_err_o  out  1  qualified by resp_valid_o; misaligned, illegal funct3, or out-of-bounds.
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata_o  out  32  full word to write.
- mem_re_o  out  1  read enable.
- mem_we_o  out  1  write enable, held for exactly one clk_i cycle per write.
- mem_rdata_i  in  32  combinational read data from memory.

Behaviour:
- Reset: state = IDLE and all captured registers cleared.
  - Output reset values: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mem_re_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset in any state aborts the operation. No mem_we_o pulse follows the reset cycle.
- Capture on accept: we, funct3, addr and wdata are registered. The core may change its inputs afterwards.
- Error check, evaluated at accept:
  - H/HU with addr[0]=1 is an error.
  - W with addr[1:0]!=0 is an error.
  - funct3 outside the legal set is an error (011, 110, 111; and 100/101 on stores).
- Memory outputs: mem_re_o and mem_we_o are never high together. mem_addr_o and mem_wdata_o are zero when both enables are low.
- State machine, registered (cycle 0 = accept cycle):
  - IDLE: on accept with an error → RESP. Load → LOAD. SW → WR. SB/SH → RMW_RD.
  - LOAD: mem_re_o=1. Register the extracted and extended mem_rdata_i → RESP.
  - RMW_RD: mem_re_o=1. Register the merged word → WR.
    - SB replaces byte addr[1:0].
    - SH replaces halfword addr[1].
  - WR: mem_we_o=1 and mem_wdata_o = merged word (RMW) or wdata (SW) → RESP.
  - RESP: resp_valid_o=1, resp_rdata_o and resp_err_o driven → IDLE.
- Latency, accept cycle to resp_valid_o:
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Throughput is one request per latency+1 cycles. A new request may be accepted in the cycle after RESP.
- Load extract, little-endian:
  - Byte = word[8*addr[1:0] +: 8].
  - Halfword = word[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend.
- On error no memory access is made and resp_rdata_o=0.
- No response backpressure: the core must sample resp_valid_o on the cycle it is high.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined: an access whose aligned word address + 3 ≥ MEM_BYTES is an error. It is detected at accept, with 1-cycle latency and no memory access.
- Undefined: no bounds check. The address is passed through unchanged and out-of-range behaviour is the memory's.

Test Plan:
All tests preload memory word 0x10 = 0x8899AABB.
- LB 0x13 → cycle 2 resp_valid_o=1, rdata 0xFFFFFF88, err 0. LBU 0x13 → 0x00000088.
- LH 0x12 → 0xFFFF8899. LHU 0x10 → 0x0000AABB. LW 0x10 → 0x8899AABB. mem_addr_o=0x10 in the LOAD cycle for all.
- SB 0x11, wdata 0x123456CC:
  - cycle 1: mem_re_o=1.
  - cycle 2: mem_we_o=1, mem_wdata_o=0x8899CCBB.
  - cycle 3: resp_valid_o=1.
  - A following LW 0x10 returns 0x8899CCBB.
- SH 0x12, wdata 0x00001234 → written word 0x1234AABB. SW 0x10, wdata 0xDEADBEEF → mem_we_o in cycle 1, resp in cycle 2.
- Errors, each giving resp at cycle 1 with err=1, rdata=0 and mem_re_o/mem_we_o low throughout:
  - LW 0x12.
  - SH 0x11.
  - funct3=011.
- rst_i high during RMW_RD of SB 0x10 → next cycle IDLE with req_ready_o=1, no mem_we_o pulse, word 0x10 still 0x8899AABB.
- With LSU_BOUNDS_CHECK_EN: LW 0x400 → err=1 at cycle 1. Without it: mem_re_o=1 with mem_addr_o=0x400.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store unit, initiator side of the data memory interface. Converts
//   RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned
//   whole-word memory transactions. Loads extract and sign/zero-extend the
//   addressed byte or halfword. Sub-word stores are done as
//   read-modify-write. Misaligned accesses and illegal funct3 are reported
//   as errors without touching memory.
//
// Optional feature (compile-time macro):
//   LSU_BOUNDS_CHECK_EN  - when defined, an access whose aligned word
//                          address + 3 >= MEM_BYTES is an error, detected
//                          at accept. When undefined the address is passed
//                          through unchanged.
//
// Parameters:
//   MEM_BYTES     data memory size in bytes (bounds check only)
//
// Ports:
//   clk_i         clock, all state updates on posedge
//   rst_i         synchronous active-high reset
//   req_valid_i   core requests an access
//   req_ready_o   high only in IDLE; accept = req_valid_i && req_ready_o
//   req_we_i      1 = store, 0 = load
//   req_funct3_i  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr_i    byte address
//   req_wdata_i   store data (low bits used for SB/SH)
//   resp_valid_o  one-cycle completion pulse
//   resp_rdata_o  extended load data, 0 for stores and errors
//   resp_err_o    error flag, qualified by resp_valid_o
//   mem_addr_o    word-aligned memory address
//   mem_wdata_o   full word to write
//   mem_re_o      memory read enable
//   mem_we_o      memory write enable (one cycle per write)
//   mem_rdata_i   combinational memory read data
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  // funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory size widened by one bit so "address + 3" cannot wrap.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  // Request legality: alignment, funct3 legality and (optionally) bounds.
  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr[0];
      F3_W:    err = (addr[1:0] != 2'b00);
      F3_BU:   err = we;              // no unsigned store variant
      F3_HU:   err = we | addr[0];
      default: err = 1'b1;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if (({1'b0, addr[31:2], 2'b00} + 33'd3) >= MEM_LIMIT) begin
      err = 1'b1;
    end else begin
      err = err;
    end
`endif
    return err;
  endfunction

  // Little-endian byte/halfword extraction with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'd0, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'd0, h};
      F3_W:    res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Merge store data into the word read back for a sub-word store.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] res;
    res = old_word;
    case (f3)
      F3_B:    res[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = old_word;
    endcase
    return res;
  endfunction

  logic [2:0]  state_q,      state_d;
  logic        we_q,         we_d;
  logic [2:0]  funct3_q,     funct3_d;
  logic [31:0] addr_q,       addr_d;
  logic [31:0] wdata_q,      wdata_d;     // store data, later merged word
  logic        req_ready_q,  req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q,   resp_err_d;
  logic        mem_re_q,     mem_re_d;
  logic        mem_we_q,     mem_we_d;
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic        accept_s;
  logic        req_err_s;

`ifndef LSU_BOUNDS_CHECK_EN
  // The memory size only matters when bounds checking is compiled in.
  logic unused_mem_limit_s;
  assign unused_mem_limit_s = ^MEM_LIMIT;
`endif

  assign accept_s  = req_valid_i & req_ready_q;
  assign req_err_s = req_error(req_we_i, req_funct3_i, req_addr_i);

  // Next-state, request capture and response data.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          if (req_err_s) begin
            state_d    = ST_RESP;
            resp_err_d = 1'b1;
          end else if (!req_we_i) begin
            state_d = ST_LOAD;
          end else if (req_funct3_i == F3_W) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (we_q) begin
          resp_rdata_d = 32'd0;
        end else begin
          resp_rdata_d = load_extract(mem_rdata_i, funct3_q, addr_q[1:0]);
        end
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        wdata_d = store_merge(mem_rdata_i, wdata_q, funct3_q, addr_q[1:0]);
        state_d = ST_WR;
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    mem_re_d     = (state_d == ST_LOAD) || (state_d == ST_RMW_RD);
    mem_we_d     = (state_d == ST_WR);
    if (mem_re_d || mem_we_d) begin
      mem_addr_d = {addr_d[31:2], 2'b00};
    end else begin
      mem_addr_d = 32'd0;
    end
    if (mem_we_d) begin
      mem_wdata_d = wdata_d;
    end else begin
      mem_wdata_d = 32'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_re_o     = mem_re_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl with a word-wide behavioural memory.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  int we_pulses = 0;
  int overlap_cnt = 0;
  int idle_junk_cnt = 0;

  // Per-cycle observations of the last request (index = cycles after accept).
  logic        o_ready [0:4];
  logic        o_valid [0:4];
  logic        o_err   [0:4];
  logic        o_re    [0:4];
  logic        o_we    [0:4];
  logic [31:0] o_rdata [0:4];
  logic [31:0] o_addr  [0:4];
  logic [31:0] o_wdata [0:4];

  lsu_mem_ctrl #(.MEM_BYTES(1024)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      we_pulses <= we_pulses + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_re && mem_we) overlap_cnt <= overlap_cnt + 1;
    if (!rst && !mem_re && !mem_we && (mem_addr != 32'd0 || mem_wdata != 32'd0))
      idle_junk_cnt <= idle_junk_cnt + 1;
  end

  task automatic sample(input int k);
    o_ready[k] = req_ready; o_valid[k] = resp_valid; o_err[k] = resp_err;
    o_re[k] = mem_re; o_we[k] = mem_we; o_rdata[k] = resp_rdata;
    o_addr[k] = mem_addr; o_wdata[k] = mem_wdata;
  endtask

  // Present one request for a single cycle, then scramble the inputs.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    sample(0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
      end
      sample(k);
    end
  endtask

  task automatic preload();
    issue(1'b1, 3'b010, 32'h10, 32'h8899_AABB);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_en: got re=%b we=%b expected 0/0", mem_re, mem_we); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [0:6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
    logic [31:0] ad  [0:6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10, 32'h10};
    logic [31:0] exp [0:6] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB,
                               32'h8899_AABB, 32'hFFFF_FFBB, 32'hFFFF_AABB};
    preload();
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, f3[i], ad[i], 32'hCAFE_F00D);
      checks++; if (o_ready[0] !== 1'b1) begin failures++; $display("FAIL load%0d_ready: got %b expected 1", i, o_ready[0]); end
      checks++; if (o_re[1] !== 1'b1 || o_addr[1] !== 32'h10) begin failures++; $display("FAIL load%0d_rd: got re=%b addr=%h expected 1/00000010", i, o_re[1], o_addr[1]); end
      checks++; if (o_valid[1] !== 1'b0 || o_valid[2] !== 1'b1 || o_valid[3] !== 1'b0) begin failures++; $display("FAIL load%0d_latency: got valid c1..c3=%b%b%b expected 010", i, o_valid[1], o_valid[2], o_valid[3]); end
      checks++; if (o_rdata[2] !== exp[i] || o_err[2] !== 1'b0) begin failures++; $display("FAIL load%0d_data: got %h err=%b expected %h err=0", i, o_rdata[2], o_err[2], exp[i]); end
      checks++; if (o_we[1] !== 1'b0 || o_we[2] !== 1'b0 || o_ready[3] !== 1'b1) begin failures++; $display("FAIL load%0d_misc: got we=%b%b ready3=%b expected 00/1", i, o_we[1], o_we[2], o_ready[3]); end
    end
  endtask

  task automatic test_store_byte();
    preload();
    issue(1'b1, 3'b000, 32'h11, 32'h1234_56CC);
    checks++; if (o_re[1] !== 1'b1 || o_we[1] !== 1'b0 || o_addr[1] !== 32'h10) begin failures++; $display("FAIL sb_c1: got re=%b we=%b addr=%h expected 1/0/00000010", o_re[1], o_we[1], o_addr[1]); end
    checks++; if (o_we[2] !== 1'b1 || o_re[2] !== 1'b0 || o_wdata[2] !== 32'h8899_CCBB) begin failures++; $display("FAIL sb_c2: got we=%b re=%b wdata=%h expected 1/0/8899ccbb", o_we[2], o_re[2], o_wdata[2]); end
    checks++; if (o_valid[2] !== 1'b0 || o_valid[3] !== 1'b1 || o_err[3] !== 1'b0 || o_rdata[3] !== 32'd0) begin failures++; $display("FAIL sb_resp: got v2=%b v3=%b err=%b rdata=%h expected 0/1/0/0", o_valid[2], o_valid[3], o_err[3], o_rdata[3]); end
    checks++; if (o_we[3] !== 1'b0) begin failures++; $display("FAIL sb_we_len: got we c3=%b expected 0", o_we[3]); end
    issue(1'b0, 3'b010, 32'h10, 32'd0);
    checks++; if (o_rdata[2] !== 32'h8899_CCBB) begin failures++; $display("FAIL sb_readback: got %h expected 8899ccbb", o_rdata[2]); end
  endtask

  task automatic test_store_half();
    preload();
    issue(1'b1, 3'b001, 32'h12, 32'h0000_1234);
    checks++; if (o_we[2] !== 1'b1 || o_wdata[2] !== 32'h1234_AABB) begin failures++; $display("FAIL sh_hi: got we=%b wdata=%h expected 1/1234aabb", o_we[2], o_wdata[2]); end
    checks++; if (o_valid[3] !== 1'b1) begin failures++; $display("FAIL sh_latency: got valid c3=%b expected 1", o_valid[3]); end
    preload();
    issue(1'b1, 3'b001, 32'h10, 32'hFFFF_5678);
    checks++; if (o_wdata[2] !== 32'h8899_5678) begin failures++; $display("FAIL sh_lo: got %h expected 88995678", o_wdata[2]); end
    issue(1'b0, 3'b010, 32'h10, 32'd0);
    checks++; if (o_rdata[2] !== 32'h8899_5678) begin failures++; $display("FAIL sh_readback: got %h expected 88995678", o_rdata[2]); end
  endtask

  task automatic test_store_word();
    preload();
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    checks++; if (o_we[1] !== 1'b1 || o_re[1] !== 1'b0 || o_wdata[1] !== 32'hDEAD_BEEF || o_addr[1] !== 32'h10) begin failures++; $display("FAIL sw_c1: got we=%b re=%b wdata=%h addr=%h expected 1/0/deadbeef/10", o_we[1], o_re[1], o_wdata[1], o_addr[1]); end
    checks++; if (o_valid[2] !== 1'b1 || o_we[2] !== 1'b0 || o_wdata[2] !== 32'd0 || o_addr[2] !== 32'd0) begin failures++; $display("FAIL sw_c2: got valid=%b we=%b wdata=%h addr=%h expected 1/0/0/0", o_valid[2], o_we[2], o_wdata[2], o_addr[2]); end
    issue(1'b0, 3'b010, 32'h10, 32'd0);
    checks++; if (o_rdata[2] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_readback: got %h expected deadbeef", o_rdata[2]); end
  endtask

  task automatic test_errors();
    logic        we [0:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [0:6] = '{3'b010, 3'b001, 3'b011, 3'b001, 3'b100, 3'b110, 3'b111};
    logic [31:0] ad [0:6] = '{32'h12, 32'h11, 32'h10, 32'h13, 32'h10, 32'h10, 32'h10};
    preload();
    for (int i = 0; i < 7; i++) begin
      issue(we[i], f3[i], ad[i], 32'h1111_2222);
      checks++; if (o_valid[1] !== 1'b1 || o_err[1] !== 1'b1 || o_rdata[1] !== 32'd0) begin failures++; $display("FAIL err%0d_resp: got valid=%b err=%b rdata=%h expected 1/1/0", i, o_valid[1], o_err[1], o_rdata[1]); end
      checks++; if ((o_re[1] | o_re[2] | o_re[3] | o_we[1] | o_we[2] | o_we[3]) !== 1'b0) begin failures++; $display("FAIL err%0d_noaccess: got re=%b%b%b we=%b%b%b expected all 0", i, o_re[1], o_re[2], o_re[3], o_we[1], o_we[2], o_we[3]); end
      checks++; if (o_ready[2] !== 1'b1 || o_valid[2] !== 1'b0) begin failures++; $display("FAIL err%0d_idle: got ready=%b valid=%b expected 1/0", i, o_ready[2], o_valid[2]); end
    end
    issue(1'b0, 3'b010, 32'h10, 32'd0);
    checks++; if (o_rdata[2] !== 32'h8899_AABB) begin failures++; $display("FAIL err_mem_intact: got %h expected 8899aabb", o_rdata[2]); end
  endtask

  task automatic test_reset_mid_rmw();
    int pulses_before;
    preload();
    pulses_before = we_pulses;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h0000_0077;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_re !== 1'b1) begin failures++; $display("FAIL rst_rmw_rd: got re=%b expected 1", mem_re); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL rst_rmw_idle: got ready=%b we=%b re=%b valid=%b expected 1/0/0/0", req_ready, mem_we, mem_re, resp_valid); end
    repeat (4) @(negedge clk);
    checks++; if (we_pulses !== pulses_before) begin failures++; $display("FAIL rst_rmw_nowrite: got %0d write pulses expected %0d", we_pulses, pulses_before); end
    issue(1'b0, 3'b010, 32'h10, 32'd0);
    checks++; if (o_rdata[2] !== 32'h8899_AABB) begin failures++; $display("FAIL rst_rmw_mem: got %h expected 8899aabb", o_rdata[2]); end
  endtask

  task automatic test_bounds();
    issue(1'b0, 3'b010, 32'h3FC, 32'd0);
    checks++; if (o_re[1] !== 1'b1 || o_addr[1] !== 32'h3FC || o_err[2] !== 1'b0 || o_valid[2] !== 1'b1) begin failures++; $display("FAIL bounds_last_word: got re=%b addr=%h err=%b valid=%b expected 1/3fc/0/1", o_re[1], o_addr[1], o_err[2], o_valid[2]); end
    issue(1'b0, 3'b010, 32'h400, 32'd0);
`ifdef LSU_BOUNDS_CHECK_EN
    checks++; if (o_valid[1] !== 1'b1 || o_err[1] !== 1'b1 || o_re[1] !== 1'b0) begin failures++; $display("FAIL bounds_oob: got valid=%b err=%b re=%b expected 1/1/0", o_valid[1], o_err[1], o_re[1]); end
`else
    checks++; if (o_re[1] !== 1'b1 || o_addr[1] !== 32'h400 || o_valid[1] !== 1'b0) begin failures++; $display("FAIL bounds_passthru: got re=%b addr=%h valid=%b expected 1/400/0", o_re[1], o_addr[1], o_valid[1]); end
`endif
  endtask

  task automatic test_back_to_back();
    logic exp_ready [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_valid [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    preload();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (req_ready !== exp_ready[k] || resp_valid !== exp_valid[k]) begin failures++; $display("FAIL b2b_c%0d: got ready=%b valid=%b expected %b/%b", k, req_ready, resp_valid, exp_ready[k], exp_valid[k]); end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_invariants();
    checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL re_we_overlap: got %0d cycles expected 0", overlap_cnt); end
    checks++; if (idle_junk_cnt !== 0) begin failures++; $display("FAIL idle_bus_nonzero: got %0d cycles expected 0", idle_junk_cnt); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_byte();
    test_store_half();
    test_store_word();
    test_errors();
    test_reset_mid_rmw();
    test_bounds();
    test_back_to_back();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
